// File: rtl/me_search_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : me_search_ctrl
//  Purpose  : Runs one full-search motion-estimation pass over a 32x32 CU.
//             Candidate MVs are issued in raster order to the fetch/SAD
//             pipeline under a MAX_OUT credit. A best SAD and MV are kept for
//             each of the four 16x16 partitions.
//  Ports    : clk, rst (async, active high)
//             start / busy / done / cmp_clr         - pass control
//             cand_valid / cand_ready / cand_mv*    - candidate issue
//             sad_valid / sad16x16                  - in-order SAD returns
//             best_sad / best_mv / early_term       - per-partition result
//  Option   : `define ME_EARLY_TERM_EN enables early termination. A pass
//             stops issuing once all four best SADs are below ET_THR.
//  Revision : 1.0 - initial release
// ============================================================================
module me_search_ctrl #(
    parameter int SR      = 16,
    parameter int MVW     = 6,
    parameter int MAX_OUT = 8,
    parameter int ET_THR  = 512
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  cmp_clr,
    output logic                  cand_valid,
    input  logic                  cand_ready,
    output logic signed [MVW-1:0] cand_mvx,
    output logic signed [MVW-1:0] cand_mvy,
    input  logic                  sad_valid,
    input  logic [63:0]           sad16x16,
    output logic [63:0]           best_sad,
    output logic [8*MVW-1:0]      best_mv,
    output logic                  early_term
);

    localparam int N_CAND = 4 * SR * SR;
    localparam int CW     = $clog2(N_CAND + 1);
    localparam int OW     = $clog2(MAX_OUT + 1);

    localparam logic [MVW-1:0] c_mv_min  = MVW'(-SR);
    localparam logic [MVW-1:0] c_mv_max  = MVW'(SR - 1);
    localparam logic [CW-1:0]  c_n_cand  = CW'(N_CAND);
    localparam logic [OW-1:0]  c_max_out = OW'(MAX_OUT);
    localparam logic [16:0]    c_et_thr  = 17'(ET_THR);

`ifdef ME_EARLY_TERM_EN
    localparam logic c_et_en = 1'b1;
`else
    localparam logic c_et_en = 1'b0;
`endif

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_clear = 3'd1;
    localparam logic [2:0] c_st_scan  = 3'd2;
    localparam logic [2:0] c_st_drain = 3'd3;
    localparam logic [2:0] c_st_done  = 3'd4;

    logic [2:0]       r_state;
    logic [MVW-1:0]   r_mvx, r_mvy;     // next MV to issue
    logic [MVW-1:0]   r_rmvx, r_rmvy;   // MV that the next return belongs to
    logic [CW-1:0]    r_ret_cnt;
    logic [OW-1:0]    r_outst;
    logic [63:0]      r_best_sad;
    logic [8*MVW-1:0] r_best_mv;
    logic             r_et_pend;        // pass is draining after early termination
    logic             r_early;

    logic             w_xfer, w_ret, w_last_iss, w_et_hit;
    logic [3:0]       w_lt, w_below;

    assign busy       = (r_state != c_st_idle);
    assign done       = (r_state == c_st_done);
    assign cmp_clr    = (r_state == c_st_clear);
    assign cand_valid = (r_state == c_st_scan) && (r_outst < c_max_out);
    assign cand_mvx   = r_mvx;
    assign cand_mvy   = r_mvy;
    assign best_sad   = r_best_sad;
    assign best_mv    = r_best_mv;
    assign early_term = r_early & c_et_en;

    assign w_xfer     = cand_valid && cand_ready;
    // Returns only count while a pass is collecting and something is in flight.
    assign w_ret      = sad_valid && (r_outst != '0) &&
                        ((r_state == c_st_scan) || (r_state == c_st_drain));
    assign w_last_iss = (r_mvx == c_mv_max) && (r_mvy == c_mv_max);

    // Per-partition compare. w_below looks at the post-update best, so the
    // early-termination decision sees the result currently being returned.
    for (genvar p = 0; p < 4; p++) begin : g_part
        logic [15:0] w_sad, w_cur, w_post;
        assign w_sad      = sad16x16[p*16 +: 16];
        assign w_cur      = r_best_sad[p*16 +: 16];
        assign w_lt[p]    = (w_sad < w_cur);
        assign w_post     = w_lt[p] ? w_sad : w_cur;
        assign w_below[p] = ({1'b0, w_post} < c_et_thr);
    end

    assign w_et_hit = c_et_en && w_ret && (r_state == c_st_scan) && (&w_below);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_st_idle;
            r_mvx      <= '0;
            r_mvy      <= '0;
            r_rmvx     <= '0;
            r_rmvy     <= '0;
            r_ret_cnt  <= '0;
            r_outst    <= '0;
            r_best_sad <= '1;
            r_best_mv  <= '0;
            r_et_pend  <= 1'b0;
            r_early    <= 1'b0;
        end else begin
            // A simultaneous issue and return leaves the credit count unchanged.
            if (w_xfer && !w_ret) begin
                r_outst <= r_outst + 1'b1;
            end else if (w_ret && !w_xfer) begin
                r_outst <= r_outst - 1'b1;
            end

            if (w_xfer) begin
                if (r_mvx == c_mv_max) begin
                    r_mvx <= c_mv_min;
                    r_mvy <= r_mvy + 1'b1;
                end else begin
                    r_mvx <= r_mvx + 1'b1;
                end
            end

            // Results carry no MV; the return raster follows issue order.
            if (w_ret) begin
                r_ret_cnt <= r_ret_cnt + 1'b1;
                if (r_rmvx == c_mv_max) begin
                    r_rmvx <= c_mv_min;
                    r_rmvy <= r_rmvy + 1'b1;
                end else begin
                    r_rmvx <= r_rmvx + 1'b1;
                end
                // Strict compare: on a tie the earlier candidate is kept.
                for (int p = 0; p < 4; p++) begin
                    if (w_lt[p]) begin
                        r_best_sad[p*16 +: 16]        <= sad16x16[p*16 +: 16];
                        r_best_mv[p*2*MVW +: 2*MVW]   <= {r_rmvy, r_rmvx};
                    end
                end
            end

            case (r_state)
                c_st_idle: begin
                    if (start) r_state <= c_st_clear;
                end
                c_st_clear: begin
                    r_mvx      <= c_mv_min;
                    r_mvy      <= c_mv_min;
                    r_rmvx     <= c_mv_min;
                    r_rmvy     <= c_mv_min;
                    r_ret_cnt  <= '0;
                    r_outst    <= '0;
                    r_best_sad <= '1;
                    r_best_mv  <= '0;
                    r_et_pend  <= 1'b0;
                    r_early    <= 1'b0;
                    r_state    <= c_st_scan;
                end
                c_st_scan: begin
                    if (w_et_hit) begin
                        r_et_pend <= 1'b1;
                        r_state   <= c_st_drain;
                    end else if (w_xfer && w_last_iss) begin
                        r_state   <= c_st_drain;
                    end
                end
                c_st_drain: begin
                    // An early-terminated pass only waits for in-flight results.
                    if (r_et_pend ? (r_outst == '0) : (r_ret_cnt == c_n_cand)) begin
                        r_early <= r_et_pend;
                        r_state <= c_st_done;
                    end
                end
                c_st_done: begin
                    r_state <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_me_search_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_me_search_ctrl
//  Purpose  : Self-checking bench for me_search_ctrl (SR=2, 16 candidates).
//             A downstream model returns SADs from a per-candidate table
//             with fixed or random latency. A reference computes the raster
//             MVs, per-partition minima and early termination independently.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_me_search_ctrl;

    localparam int SR      = 2;
    localparam int MVW     = 6;
    localparam int MAX_OUT = 3;
    localparam int ET_THR  = 512;
    localparam int N       = (2*SR) * (2*SR);

`ifdef ME_EARLY_TERM_EN
    localparam bit c_et_en = 1'b1;
`else
    localparam bit c_et_en = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  start = 1'b0;
    logic                  cand_ready = 1'b0;
    logic                  sad_valid = 1'b0;
    logic [63:0]           sad16x16 = '0;
    logic                  busy, done, cmp_clr, cand_valid, early_term;
    logic signed [MVW-1:0] cand_mvx, cand_mvy;
    logic [63:0]           best_sad;
    logic [8*MVW-1:0]      best_mv;

    int          n_checks = 0;
    int          n_fail   = 0;
    string       cur_test = "reset";
    logic [63:0] tab [N];

    me_search_ctrl #(.SR(SR), .MVW(MVW), .MAX_OUT(MAX_OUT), .ET_THR(ET_THR)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .cmp_clr(cmp_clr), .cand_valid(cand_valid), .cand_ready(cand_ready),
        .cand_mvx(cand_mvx), .cand_mvy(cand_mvy), .sad_valid(sad_valid),
        .sad16x16(sad16x16), .best_sad(best_sad), .best_mv(best_mv),
        .early_term(early_term)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s/%s got=%0h exp=%0h t=%0t", cur_test, tag, obs, exp, $time);
        end
    endtask

    function automatic logic [MVW-1:0] ras_x(input int k);
        ras_x = MVW'(k % (2*SR) - SR);
    endfunction

    function automatic logic [MVW-1:0] ras_y(input int k);
        ras_y = MVW'(k / (2*SR) - SR);
    endfunction

    task automatic chk_reset_vals();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_clr", cmp_clr, 0);
        chk("rst_cvalid", cand_valid, 0);
        chk("rst_mvx", $unsigned(cand_mvx), 0);
        chk("rst_mvy", $unsigned(cand_mvy), 0);
        chk("rst_bsad", best_sad, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("rst_bmv", best_mv, 0);
        chk("rst_et", early_term, 0);
    endtask

    task automatic fill_random();
        for (int k = 0; k < N; k++)
            tab[k] = {16'($urandom_range(600, 4000)), 16'($urandom_range(600, 4000)),
                      16'($urandom_range(600, 4000)), 16'($urandom_range(600, 4000))};
    endtask

    // lat>0: fixed latency, lat==0: random 1..6.
    // rdy_mode 0: always ready, 1: toggling, 2: random.
    task automatic run_pass(input string name, input int lat, input int rdy_mode,
                            input int abort_at, input bit spurious);
        int q_k[$];
        int q_due[$];
        int k_iss, n_ret, cyc, n_done, n_clr, last_due, rk, due;
        bit fin, stalled, m_et, scanning, xfer, below, sp_scan;
        logic [MVW-1:0]   st_x, st_y;
        logic [15:0]      m_sad [4];
        logic [2*MVW-1:0] m_mv [4];

        cur_test = name;
        k_iss = 0; n_ret = 0; cyc = 0; n_done = 0; n_clr = 0; last_due = 0;
        fin = 0; stalled = 0; m_et = 0; sp_scan = 0; st_x = '0; st_y = '0;
        for (int p = 0; p < 4; p++) begin m_sad[p] = '1; m_mv[p] = '0; end

        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("clr_pulse", cmp_clr, 1);
        chk("busy_rise", busy, 1);

        while (!fin && cyc < 1000) begin
            if (abort_at > 0 && k_iss >= abort_at) begin
                rst = 1'b1;
                #1;
                chk_reset_vals();
                @(negedge clk);
                rst = 1'b0;
                sad_valid = 1'b0;
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    chk("abort_done", done, 0);
                    chk("abort_busy", busy, 0);
                end
                chk("abort_ndone", n_done, 0);
                return;
            end

            if (spurious && k_iss == 5 && !sp_scan) begin
                start = 1'b1;
                sp_scan = 1;
            end else begin
                start = 1'b0;
            end

            case (rdy_mode)
                0:       cand_ready = 1'b1;
                1:       cand_ready = cyc[0];
                default: cand_ready = 1'($urandom_range(0, 1));
            endcase

            rk = -1;
            if (q_k.size() > 0 && q_due[0] <= cyc) begin
                rk = q_k.pop_front();
                void'(q_due.pop_front());
                sad_valid = 1'b1;
                sad16x16  = tab[rk];
            end else begin
                sad_valid = 1'b0;
                sad16x16  = {$urandom, $urandom};
            end

            if (cmp_clr) n_clr++;
            if (stalled && !m_et) begin
                chk("stall_valid", cand_valid, 1);
                chk("stall_x", $unsigned(cand_mvx), st_x);
                chk("stall_y", $unsigned(cand_mvy), st_y);
            end
            if (k_iss >= N || m_et) begin
                chk("no_issue", cand_valid, 0);
            end else if (cand_valid) begin
                chk("mvx", $unsigned(cand_mvx), ras_x(k_iss));
                chk("mvy", $unsigned(cand_mvy), ras_y(k_iss));
            end

            scanning = (k_iss < N) && !m_et;
            xfer     = cand_valid && cand_ready;

            if (rk >= 0) begin
                n_ret++;
                for (int p = 0; p < 4; p++) begin
                    if (tab[rk][p*16 +: 16] < m_sad[p]) begin
                        m_sad[p] = tab[rk][p*16 +: 16];
                        m_mv[p]  = {ras_y(rk), ras_x(rk)};
                    end
                end
                below = 1;
                for (int p = 0; p < 4; p++) if (m_sad[p] >= ET_THR) below = 0;
                if (c_et_en && scanning && below) m_et = 1;
            end

            if (xfer) begin
                due = cyc + ((lat > 0) ? lat : int'($urandom_range(1, 6)));
                if (due <= last_due) due = last_due + 1;
                q_k.push_back(k_iss);
                q_due.push_back(due);
                last_due = due;
                k_iss++;
            end
            stalled = cand_valid && !cand_ready;
            st_x    = cand_mvx;
            st_y    = cand_mvy;
            chk("credit", 64'((k_iss - n_ret) <= MAX_OUT), 1);

            if (done) begin
                n_done++;
                fin = 1;
                chk("done_busy", busy, 1);
                chk("early_term", early_term, m_et);
                if (!m_et) chk("issued", k_iss, N);
                chk("returned", n_ret, k_iss);
                for (int p = 0; p < 4; p++) begin
                    chk("best_sad", best_sad[p*16 +: 16], m_sad[p]);
                    chk("best_mv", best_mv[p*2*MVW +: 2*MVW], m_mv[p]);
                end
                if (spurious) start = 1'b1;
            end

            @(negedge clk);
            cyc++;
        end

        start = 1'b0;
        if (!fin) chk("timeout", 0, 1);
        for (int i = 0; i < 4; i++) begin
            chk("idle_busy", busy, 0);
            chk("idle_done", done, 0);
            chk("idle_clr", cmp_clr, 0);
            @(negedge clk);
        end
        chk("one_done", n_done, 1);
        chk("one_clr", n_clr, 1);
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk_reset_vals();
        rst = 1'b0;
        @(negedge clk);

        // Descending ramp: last candidate wins on every lane.
        for (int k = 0; k < N; k++) tab[k] = {4{16'(1000 - k)}};
        run_pass("ramp", 3, 0, 0, 0);

        // Equal minimum on lane 2 at candidates 5 and 9: the earlier one is kept.
        for (int k = 0; k < N; k++) tab[k] = {4{16'd700}};
        tab[5][47:32] = 16'd50;
        tab[9][47:32] = 16'd50;
        run_pass("tie", 0, 2, 0, 0);

        fill_random();
        run_pass("toggle", 6, 1, 0, 0);

        for (int r = 0; r < 3; r++) begin
            fill_random();
            run_pass("random", 0, 2, 0, 0);
        end

        fill_random();
        run_pass("abort", 2, 0, 7, 0);
        run_pass("after_abort", 0, 2, 0, 0);

        fill_random();
        run_pass("spurious", 2, 0, 0, 1);

        // Small SAD on all lanes at candidate 3 ends the pass early when enabled.
        for (int k = 0; k < N; k++) tab[k] = {4{16'd700}};
        tab[3] = {4{16'd100}};
        run_pass("early", 3, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
